// File: rtl/hilo_pkg.sv
// hilo_pkg: shared op encoding, FSM states and default width for the HI/LO multiply sequencer
package hilo_pkg;
   localparam int DEF_WIDTH = 32;
   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_MTHI  = 3'd3,
      OP_MTLO  = 3'd4
   } op_e;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/hilo_mul_ctrl_if.sv
// hilo_mul_ctrl_if: EX-stage, multiplier and HI/LO read-path signals of the multiply sequencer
interface hilo_mul_ctrl_if #(parameter int WIDTH = hilo_pkg::DEF_WIDTH);
   logic               valid_i;
   logic [2:0]         op_i;
   logic [WIDTH-1:0]   src_a_i;
   logic [WIDTH-1:0]   src_b_i;
   logic               flush_i;
   logic [2*WIDTH-1:0] mul_result_i;
   logic               mul_ready_i;
   logic               mul_start_o;
   logic               mul_sign_o;
   logic [WIDTH-1:0]   mul_op1_o;
   logic [WIDTH-1:0]   mul_op2_o;
   logic               stall_o;
   logic [WIDTH-1:0]   hi_o;
   logic [WIDTH-1:0]   lo_o;
   modport master (
      output valid_i, op_i, src_a_i, src_b_i, flush_i, mul_result_i, mul_ready_i,
      input  mul_start_o, mul_sign_o, mul_op1_o, mul_op2_o, stall_o, hi_o, lo_o
   );
   modport slave (
      input  valid_i, op_i, src_a_i, src_b_i, flush_i, mul_result_i, mul_ready_i,
      output mul_start_o, mul_sign_o, mul_op1_o, mul_op2_o, stall_o, hi_o, lo_o
   );
endinterface

// File: rtl/hilo_regs.sv
// hilo_regs: HI/LO architectural registers with MTHI/MTLO and product write ports
// HILO_BYPASS_EN forwards a same-cycle MTHI/MTLO value straight to the outputs.
module hilo_regs
   import hilo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hi_we,
   input  logic               lo_we,
   input  logic               prod_we,
   input  logic [WIDTH-1:0]   wdata,
   input  logic [2*WIDTH-1:0] prod,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);
   logic [WIDTH-1:0] hi_q, lo_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (prod_we) begin
         hi_q <= prod[2*WIDTH-1:WIDTH];
         lo_q <= prod[WIDTH-1:0];
      end else begin
         if (hi_we) hi_q <= wdata;
         if (lo_we) lo_q <= wdata;
      end
   end
`ifdef HILO_BYPASS_EN
   assign hi = hi_we ? wdata : hi_q;
   assign lo = lo_we ? wdata : lo_q;
`else
   assign hi = hi_q;
   assign lo = lo_q;
`endif
endmodule

// File: rtl/hilo_mul_ctrl.sv
// hilo_mul_ctrl: EX-stage sequencer for the multi-cycle multiplier, owner of HI/LO
// HILO_BYPASS_EN (optional) forwards MTHI/MTLO data to hi_o/lo_o in the write cycle.
module hilo_mul_ctrl
   import hilo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input logic           clk,
   input logic           rst,
   hilo_mul_ctrl_if.slave bus
);
   state_e state;
   logic   idle_go, mul_go, hi_we, lo_we, prod_we;
   assign idle_go = state == IDLE && bus.valid_i && !bus.flush_i;
   assign mul_go  = idle_go && (bus.op_i == OP_MULT || bus.op_i == OP_MULTU);
   assign hi_we   = idle_go && bus.op_i == OP_MTHI;
   assign lo_we   = idle_go && bus.op_i == OP_MTLO;
   assign prod_we = state == BUSY && bus.mul_ready_i && !bus.flush_i;
   assign bus.stall_o = state == BUSY || mul_go;
   // DONE swallows the retiring MULT still sitting at EX and forces a low start cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         bus.mul_start_o <= 1'b0;
         bus.mul_sign_o  <= 1'b0;
         bus.mul_op1_o   <= '0;
         bus.mul_op2_o   <= '0;
      end else if (bus.flush_i && state != IDLE) begin
         state           <= IDLE;
         bus.mul_start_o <= 1'b0;
      end else begin
         case (state)
            IDLE: if (mul_go) begin
               bus.mul_op1_o   <= bus.src_a_i;
               bus.mul_op2_o   <= bus.src_b_i;
               bus.mul_sign_o  <= bus.op_i == OP_MULT;
               bus.mul_start_o <= 1'b1;
               state           <= BUSY;
            end
            BUSY: if (bus.mul_ready_i) begin
               bus.mul_start_o <= 1'b0;
               state           <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   hilo_regs #(.WIDTH(WIDTH)) u_regs (
      .clk     (clk),
      .rst     (rst),
      .hi_we   (hi_we),
      .lo_we   (lo_we),
      .prod_we (prod_we),
      .wdata   (bus.src_a_i),
      .prod    (bus.mul_result_i),
      .hi      (bus.hi_o),
      .lo      (bus.lo_o)
   );
endmodule
